// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the pipelined N-bit adder.
//   - stage_ctl_t : per-stage control bundle (valid, ripple carry, saturate
//                   request) that travels down the pipe with each result.
//   - num_stages  : pipeline depth for a given operand and chunk width.
// Optional feature macro used by the adder files: ADDER_SAT_EN.
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef struct packed {
        logic valid;     // this stage holds a live result
        logic carry;     // carry out of the chunk added in this stage
        logic saturate;  // clamp request sampled with the operands
    } stage_ctl_t;

    function automatic int num_stages(input int num_bits, input int stage_bits);
        return num_bits / stage_bits;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// ---------------------------------------------------------------------------
// adder_stage
//   One registered STAGE_BITS-wide chunk add of the pipelined adder.
//   The incoming carry comes from the previous stage's registered control.
//   All registers move only when en (global advance) is high.
// Ports
//   clk    in   1           system clock, rising edge
//   rst    in   1           asynchronous reset, active-high
//   en     in   1           pipeline advance
//   ctl_i  in   stage_ctl_t valid/carry-in/saturate from the previous stage
//   a_i    in   STAGE_BITS  operand A chunk
//   b_i    in   STAGE_BITS  operand B chunk
//   ctl_o  out  stage_ctl_t registered valid/carry-out/saturate
//   sum_o  out  STAGE_BITS  registered chunk sum
//   ovf_o  out  1           registered signed-overflow of this chunk's MSB
// ---------------------------------------------------------------------------
module adder_stage
    import adder_pkg::*;
#(
    parameter int STAGE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  stage_ctl_t            ctl_i,
    input  logic [STAGE_BITS-1:0] a_i,
    input  logic [STAGE_BITS-1:0] b_i,
    output stage_ctl_t            ctl_o,
    output logic [STAGE_BITS-1:0] sum_o,
    output logic                  ovf_o
);

    stage_ctl_t            ctl_q, ctl_d;
    logic [STAGE_BITS-1:0] sum_q, sum_d;
    logic                  ovf_q, ovf_d;
    logic [STAGE_BITS:0]   chunk_full;
    logic                  msb_carry_in;

    always_comb begin
        chunk_full = {1'b0, a_i} + {1'b0, b_i} + {{STAGE_BITS{1'b0}}, ctl_i.carry};
        // Carry into the chunk MSB recovered from the MSB sum bit.
        msb_carry_in = a_i[STAGE_BITS-1] ^ b_i[STAGE_BITS-1] ^ chunk_full[STAGE_BITS-1];
        ctl_d = ctl_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (en) begin
            ctl_d.valid    = ctl_i.valid;
            ctl_d.carry    = chunk_full[STAGE_BITS];
            ctl_d.saturate = ctl_i.saturate;
            sum_d          = chunk_full[STAGE_BITS-1:0];
            ovf_d          = chunk_full[STAGE_BITS] ^ msb_carry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ctl_q <= ctl_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign ctl_o = ctl_q;
    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipelined_adder_nbit.sv
// ---------------------------------------------------------------------------
// pipelined_adder_nbit
//   Pipelined N-bit adder: the carry ripples across STAGE_BITS-wide chunks,
//   one chunk per clock, latency NUM_BITS/STAGE_BITS cycles, one add per cycle.
//   Ready/valid on both sides with a global stall (no stage moves while the
//   output is valid and not accepted).
// Ports
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous reset, active-high
//   in_valid   in   1         a, b, carry_in valid
//   in_ready   out  1         operands accepted this cycle
//   a, b       in   NUM_BITS  operands
//   carry_in   in   1         carry into bit 0
//   saturate   in   1         (ADDER_SAT_EN only) clamp sum to all ones on carry out
//   out_valid  out  1         result valid
//   out_ready  in   1         sink accepts the result
//   sum        out  NUM_BITS  (a+b+carry_in) mod 2^NUM_BITS (or all ones if clamped)
//   carry_out  out  1         unsigned carry out of the MSB
//   overflow   out  1         two's-complement overflow
// Optional feature macro: ADDER_SAT_EN (adds the saturate port).
// ---------------------------------------------------------------------------
module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int NUM_BITS   = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
`ifdef ADDER_SAT_EN
    input  logic                saturate,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);

    localparam int NUM_STAGES = num_stages(NUM_BITS, STAGE_BITS);

    if (NUM_BITS % STAGE_BITS != 0) begin : g_bad_width
        $error("pipelined_adder_nbit: NUM_BITS must be a multiple of STAGE_BITS");
    end

    logic advance;
    logic sat_in;

`ifdef ADDER_SAT_EN
    assign sat_in = saturate;
`else
    assign sat_in = 1'b0;
`endif

    stage_ctl_t            ctl_in    [NUM_STAGES];
    stage_ctl_t            ctl_out   [NUM_STAGES];
    logic [STAGE_BITS-1:0] a_chunk   [NUM_STAGES];
    logic [STAGE_BITS-1:0] b_chunk   [NUM_STAGES];
    logic [STAGE_BITS-1:0] sum_chunk [NUM_STAGES];
    logic                  ovf_chunk [NUM_STAGES];

    // Operand skew: stage k carries the operands so stage k+1 can pick its
    // chunk. Sum skew: stage k carries the finished chunks 0..k-1.
    logic [NUM_BITS-1:0] a_skew_q [NUM_STAGES];
    logic [NUM_BITS-1:0] a_skew_d [NUM_STAGES];
    logic [NUM_BITS-1:0] b_skew_q [NUM_STAGES];
    logic [NUM_BITS-1:0] b_skew_d [NUM_STAGES];
    logic [NUM_BITS-1:0] sum_lo_q [NUM_STAGES];
    logic [NUM_BITS-1:0] sum_lo_d [NUM_STAGES];

    logic [NUM_BITS-1:0] raw_sum;

    assign out_valid = ctl_out[NUM_STAGES-1].valid;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    always_comb begin
        // Stage 0 is fed straight from the ports. Its valid bit may latch
        // in_valid directly: stage 0 only loads when in_ready is high.
        ctl_in[0].valid    = in_valid;
        ctl_in[0].carry    = carry_in;
        ctl_in[0].saturate = sat_in;
        a_chunk[0]         = a[STAGE_BITS-1:0];
        b_chunk[0]         = b[STAGE_BITS-1:0];
        a_skew_d[0]        = advance ? a : a_skew_q[0];
        b_skew_d[0]        = advance ? b : b_skew_q[0];
        sum_lo_d[0]        = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            ctl_in[k]  = ctl_out[k-1];
            a_chunk[k] = a_skew_q[k-1][k*STAGE_BITS +: STAGE_BITS];
            b_chunk[k] = b_skew_q[k-1][k*STAGE_BITS +: STAGE_BITS];
            a_skew_d[k] = advance ? a_skew_q[k-1] : a_skew_q[k];
            b_skew_d[k] = advance ? b_skew_q[k-1] : b_skew_q[k];
            sum_lo_d[k] = sum_lo_q[k-1];
            sum_lo_d[k][(k-1)*STAGE_BITS +: STAGE_BITS] = sum_chunk[k-1];
            if (!advance) begin
                sum_lo_d[k] = sum_lo_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_skew_q[k] <= '0;
                b_skew_q[k] <= '0;
                sum_lo_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_skew_q[k] <= a_skew_d[k];
                b_skew_q[k] <= b_skew_d[k];
                sum_lo_q[k] <= sum_lo_d[k];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        adder_stage #(
            .STAGE_BITS (STAGE_BITS)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (advance),
            .ctl_i (ctl_in[gi]),
            .a_i   (a_chunk[gi]),
            .b_i   (b_chunk[gi]),
            .ctl_o (ctl_out[gi]),
            .sum_o (sum_chunk[gi]),
            .ovf_o (ovf_chunk[gi])
        );
    end

    always_comb begin
        raw_sum = sum_lo_q[NUM_STAGES-1];
        raw_sum[(NUM_STAGES-1)*STAGE_BITS +: STAGE_BITS] = sum_chunk[NUM_STAGES-1];
        carry_out = ctl_out[NUM_STAGES-1].carry;
        overflow  = ovf_chunk[NUM_STAGES-1];
        // Clamping only touches the sum; the flags always report the raw add.
        if (ctl_out[NUM_STAGES-1].saturate && ctl_out[NUM_STAGES-1].carry) begin
            sum = '1;
        end else begin
            sum = raw_sum;
        end
    end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
module tb_pipelined_adder_nbit;

    localparam int NB  = 16;
    localparam int SB  = 4;
    localparam int NS  = NB / SB;
    localparam int NB2 = 4;
    localparam int SB2 = 2;
    localparam int NS2 = NB2 / SB2;
`ifdef ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          in_valid = 1'b0, in_ready, carry_in = 1'b0, saturate = 1'b0;
    logic [NB-1:0] a = '0, b = '0, sum;
    logic          out_valid, out_ready = 1'b1, carry_out, overflow;

    logic           in_valid2 = 1'b0, in_ready2, carry_in2 = 1'b0, saturate2 = 1'b0;
    logic [NB2-1:0] a2 = '0, b2 = '0, sum2;
    logic           out_valid2, out_ready2 = 1'b1, carry_out2, overflow2;

    exp_t q[$];
    exp_t q2[$];
    int   cyc = 0;
    int   stall_cnt = 0;
    int   n_total = 0;
    int   n_pass = 0;
    bit   done = 1'b0;

    logic          prev_stall = 1'b0;
    logic [NB-1:0] prev_sum;
    logic          prev_cout, prev_ovf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_nbit #(.NUM_BITS(NB), .STAGE_BITS(SB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in),
`ifdef ADDER_SAT_EN
        .saturate(saturate),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    pipelined_adder_nbit #(.NUM_BITS(NB2), .STAGE_BITS(SB2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .carry_in(carry_in2),
`ifdef ADDER_SAT_EN
        .saturate(saturate2),
`endif
        .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
        .carry_out(carry_out2), .overflow(overflow2)
    );

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int nb, input logic [15:0] av, input logic [15:0] bv,
                                   input logic cinv, input logic satv);
        exp_t   m;
        longint lim, full, sa, sbv, s;
        lim  = longint'(1) << nb;
        full = longint'(av) + longint'(bv) + longint'(cinv);
        m.sum  = 16'(full % lim);
        m.cout = (full >= lim);
        sa  = (longint'(av) >= lim / 2) ? longint'(av) - lim : longint'(av);
        sbv = (longint'(bv) >= lim / 2) ? longint'(bv) - lim : longint'(bv);
        s   = sa + sbv + longint'(cinv);
        m.ovf = (s >= lim / 2) || (s < -(lim / 2));
        if (SAT_BUILD && satv && m.cout) m.sum = 16'(lim - 1);
        m.cyc = 0;
        m.stalls = 0;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor / scoreboard for both instances.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_sum", {16'd0, sum}, 32'd0);
            check("rst_carry_out", {31'd0, carry_out}, 32'd0);
            check("rst_overflow", {31'd0, overflow}, 32'd0);
            check("rst_out_valid2", {31'd0, out_valid2}, 32'd0);
            check("rst_sum2", {28'd0, sum2}, 32'd0);
            q.delete();
            q2.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_sum", {16'd0, sum}, {16'd0, prev_sum});
                check("hold_flags", {30'd0, carry_out, overflow}, {30'd0, prev_cout, prev_ovf});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("dut1 out: sum=%h cout=%b ovf=%b (exp %h %b %b)",
                             sum, carry_out, overflow, e.sum, e.cout, e.ovf);
                    check("sum", {16'd0, sum}, {16'd0, e.sum});
                    check("carry_out", {31'd0, carry_out}, {31'd0, e.cout});
                    check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    check("latency", cyc - e.cyc, NS + stall_cnt - e.stalls);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = carry_out;
            prev_ovf   = overflow;
            if (prev_stall) stall_cnt++;

            if (out_valid2) begin
                if (q2.size() == 0) begin
                    check("unexpected_out2", {31'd0, out_valid2}, 32'd0);
                end else begin
                    exp_t e2;
                    e2 = q2.pop_front();
                    $display("dut2 out: sum=%h cout=%b ovf=%b (exp %h %b %b)",
                             sum2, carry_out2, overflow2, e2.sum[3:0], e2.cout, e2.ovf);
                    check("sum2", {28'd0, sum2}, {16'd0, e2.sum});
                    check("flags2", {30'd0, carry_out2, overflow2}, {30'd0, e2.cout, e2.ovf});
                    check("latency2", cyc - e2.cyc, NS2);
                end
            end

            if (cyc > 6000) begin
                $display("FAIL watchdog: cycle budget exceeded");
                $display("%0d/%0d checks passed", n_pass, n_total);
                $fatal(1, "watchdog");
            end
            if (done) begin
                check("queue_empty", q.size(), 32'd0);
                check("queue_empty2", q2.size(), 32'd0);
                $display("%0d/%0d checks passed", n_pass, n_total);
                $finish;
            end
        end
    end

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic cinv,
                         input logic satv, input logic vld, input logic ordy);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = vld; a = av; b = bv; carry_in = cinv; saturate = satv; out_ready = ordy;
        @(negedge clk);
        if (vld && in_ready) begin
            e = model(NB, av, bv, cinv, satv);
            e.cyc = cyc;
            e.stalls = stall_cnt;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    task automatic drive2(input logic [3:0] av, input logic [3:0] bv, input logic cinv,
                          input logic satv, input logic vld);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid2 = vld; a2 = av; b2 = bv; carry_in2 = cinv; saturate2 = satv;
        @(negedge clk);
        if (vld && in_ready2) begin
            e = model(NB2, {12'd0, av}, {12'd0, bv}, cinv, satv);
            e.cyc = cyc;
            q2.push_back(e);
        end
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [15:0] iv;
        logic [8:0]  sv;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1);
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1);

        for (int i = 0; i < 8; i++) begin
            iv = 16'(i);
            drive(iv, iv << 4, iv[0], 1'b0, 1'b1, 1'b1);
        end
        idle(5, 1'b1);

        // Fill the pipe, hold the sink off for 6 cycles, then release.
        for (int i = 0; i < 10; i++)
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1);
        idle(6, 1'b1);

        // Reset with three adds in flight.
        for (int i = 0; i < 3; i++)
            drive(16'h1234 + 16'(i), 16'h4321, 1'b1, 1'b0, 1'b1, 1'b1);
        rst_pulse();
        idle(8, 1'b1);

        // Reset while a nonzero result is held at the output.
        for (int i = 0; i < 6; i++)
            drive(16'h8888, 16'h1111 + 16'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        rst_pulse();
        idle(8, 1'b1);

        drive(16'hF000, 16'h2000, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(16'hF000, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1);

        for (int i = 0; i < 300; i++)
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        idle(12, 1'b1);

        // Exhaustive sweep on the narrow instance.
        for (int i = 0; i < 512; i++) begin
            sv = 9'(i);
            drive2(sv[3:0], sv[7:4], sv[8], 1'($urandom), 1'b1);
        end
        for (int i = 0; i < 4; i++) drive2(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        done = 1'b1;
    end

endmodule
